// File: rtl/am29705_ctl_if.sv
// Requester and RAM-side signal bundle for am29705_ctl.
// master = requesters plus RAM read ports, slave = the controller.
interface am29705_ctl_if;
    logic       req0, req1, wr0, wr1;
    logic [3:0] aaddr0, aaddr1, baddr0, baddr1, wdata0, wdata1;
    logic       ack0, ack1, busy;
    logic [3:0] rdata_a, rdata_b;
    logic [3:0] ram_a, ram_b, ram_d;
    logic       ram_we_, ram_le_, ram_oea_, ram_oeb_, ram_alo_;
    logic [3:0] ram_ya, ram_yb;

    modport master (
        output req0, req1, wr0, wr1, aaddr0, aaddr1, baddr0, baddr1, wdata0, wdata1,
        input  ack0, ack1, busy, rdata_a, rdata_b,
        input  ram_a, ram_b, ram_d, ram_we_, ram_le_, ram_oea_, ram_oeb_, ram_alo_,
        output ram_ya, ram_yb
    );

    modport slave (
        input  req0, req1, wr0, wr1, aaddr0, aaddr1, baddr0, baddr1, wdata0, wdata1,
        output ack0, ack1, busy, rdata_a, rdata_b,
        output ram_a, ram_b, ram_d, ram_we_, ram_le_, ram_oea_, ram_oeb_, ram_alo_,
        input  ram_ya, ram_yb
    );
endinterface

// File: rtl/am29705_ctl.sv
// Sequencer for an Am29705 two-port register file shared by two requesters.
// Define AM29705_CTL_RR_EN for round-robin arbitration; default build is fixed priority (req0 wins).
//
// state | meaning
// IDLE  | waiting for a request; grant and register operands
// SETUP | addresses settle, all strobes inactive
// LATCH | ram_le_ low for one clock (read)
// READ  | ram_oea_/ram_oeb_ low, read data captured at clock end
// WRITE | ram_we_ low for WPULSE clocks, then one hold clock
// ACK   | one-clock ack to the granted requester
module am29705_ctl #(
    parameter int WPULSE = 1
) (
    input  logic          clk,
    input  logic          rst,
    am29705_ctl_if.slave  bus
);
    typedef enum logic [2:0] {IDLE, SETUP, LATCH, READ, WRITE, ACK} state_e;

    localparam logic [2:0] WP_CNT = 3'(WPULSE);

    state_e     state_q, state_d;
    logic       gnt_q, gnt_d;
    logic       op_wr_q, op_wr_d;
    logic [3:0] ram_a_q, ram_a_d;
    logic [3:0] ram_b_q, ram_b_d;
    logic [3:0] ram_d_q, ram_d_d;
    logic [3:0] rda_q, rda_d;
    logic [3:0] rdb_q, rdb_d;
    logic [2:0] cnt_q, cnt_d;

    logic any_req, pick;
    logic we_n, le_n, oe_n, ack0, ack1;

    assign any_req = bus.req0 | bus.req1;

`ifdef AM29705_CTL_RR_EN
    // ptr_q names the requester that wins the next tie
    logic ptr_q, ptr_d;

    assign pick  = bus.req1 & (~bus.req0 | ptr_q);
    assign ptr_d = (state_q == IDLE && any_req) ? ~pick : ptr_q;

    always_ff @(posedge clk) begin
        if (rst) ptr_q <= 1'b0;
        else     ptr_q <= ptr_d;
    end
`else
    assign pick = bus.req1 & ~bus.req0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            gnt_q   <= 1'b0;
            op_wr_q <= 1'b0;
            ram_a_q <= 4'h0;
            ram_b_q <= 4'h0;
            ram_d_q <= 4'h0;
            rda_q   <= 4'h0;
            rdb_q   <= 4'h0;
            cnt_q   <= 3'd0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            op_wr_q <= op_wr_d;
            ram_a_q <= ram_a_d;
            ram_b_q <= ram_b_d;
            ram_d_q <= ram_d_d;
            rda_q   <= rda_d;
            rdb_q   <= rdb_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        op_wr_d = op_wr_q;
        ram_a_d = ram_a_q;
        ram_b_d = ram_b_q;
        ram_d_d = ram_d_q;
        rda_d   = rda_q;
        rdb_d   = rdb_q;
        cnt_d   = cnt_q;
        we_n    = 1'b1;
        le_n    = 1'b1;
        oe_n    = 1'b1;
        ack0    = 1'b0;
        ack1    = 1'b0;
        case (state_q)
            IDLE: begin
                if (any_req) begin
                    gnt_d   = pick;
                    op_wr_d = pick ? bus.wr1    : bus.wr0;
                    ram_a_d = pick ? bus.aaddr1 : bus.aaddr0;
                    ram_b_d = pick ? bus.baddr1 : bus.baddr0;
                    ram_d_d = pick ? bus.wdata1 : bus.wdata0;
                    state_d = SETUP;
                end
            end
            SETUP: begin
                if (op_wr_q) begin
                    cnt_d   = WP_CNT;
                    state_d = WRITE;
                end else begin
                    state_d = LATCH;
                end
            end
            LATCH: begin
                le_n    = 1'b0;
                state_d = READ;
            end
            READ: begin
                oe_n    = 1'b0;
                rda_d   = bus.ram_ya;
                rdb_d   = bus.ram_yb;
                state_d = ACK;
            end
            WRITE: begin
                // terminal count leaves one strobe-free hold clock before ACK
                if (cnt_q != 3'd0) begin
                    we_n  = 1'b0;
                    cnt_d = cnt_q - 3'd1;
                end else begin
                    state_d = ACK;
                end
            end
            ACK: begin
                ack0    = ~gnt_q;
                ack1    = gnt_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.ram_a    = ram_a_q;
    assign bus.ram_b    = ram_b_q;
    assign bus.ram_d    = ram_d_q;
    assign bus.ram_we_  = we_n;
    assign bus.ram_le_  = le_n;
    assign bus.ram_oea_ = oe_n;
    assign bus.ram_oeb_ = oe_n;
    assign bus.ram_alo_ = 1'b1;
    assign bus.ack0     = ack0;
    assign bus.ack1     = ack1;
    assign bus.rdata_a  = rda_q;
    assign bus.rdata_b  = rdb_q;
    assign bus.busy     = (state_q != IDLE);
endmodule

// File: tb/tb_am29705_ctl.sv
// Bench for am29705_ctl: WPULSE=1 and WPULSE=3 instances run the same operations side by side.
// Expected behaviour comes from a per-clock timeline of each operation and an array model of the RAM.
module tb_am29705_ctl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [1:0] req_v [2];
    logic       wr_v  [2];
    logic [3:0] aa_v  [2];
    logic [3:0] ba_v  [2];
    logic [3:0] wd_v  [2];
    logic       pre_we = 1'b0;
    logic [3:0] pre_addr = 4'h0;
    logic [3:0] pre_data = 4'h0;

    logic [3:0] ra_o [2], rb_o [2], rd_o [2], rda_o [2], rdb_o [2];
    logic [1:0] ack_o [2];
    logic       we_o [2], le_o [2], oea_o [2], oeb_o [2], alo_o [2], busy_o [2];

    int nvec = 0;
    int nerr = 0;
    int kcur = 0;
    logic [3:0] mem_m [16];
    logic [3:0] last_ra [2];
    logic [3:0] last_rb [2];
    logic       ptr_m [2];

    am29705_ctl_if bus [2] ();

    for (genvar g = 0; g < 2; g++) begin : g_dut
        localparam int WP = (g == 0) ? 1 : 3;
        logic [3:0] mem [16];

        am29705_ctl #(.WPULSE(WP)) u_dut (.clk(clk), .rst(rst), .bus(bus[g]));

        assign bus[g].req0   = req_v[g][0];
        assign bus[g].req1   = req_v[g][1];
        assign bus[g].wr0    = wr_v[0];
        assign bus[g].wr1    = wr_v[1];
        assign bus[g].aaddr0 = aa_v[0];
        assign bus[g].aaddr1 = aa_v[1];
        assign bus[g].baddr0 = ba_v[0];
        assign bus[g].baddr1 = ba_v[1];
        assign bus[g].wdata0 = wd_v[0];
        assign bus[g].wdata1 = wd_v[1];
        assign bus[g].ram_ya = bus[g].ram_oea_ ? 4'hF : mem[bus[g].ram_a];
        assign bus[g].ram_yb = bus[g].ram_oeb_ ? 4'hF : mem[bus[g].ram_b];

        assign ra_o[g]   = bus[g].ram_a;
        assign rb_o[g]   = bus[g].ram_b;
        assign rd_o[g]   = bus[g].ram_d;
        assign rda_o[g]  = bus[g].rdata_a;
        assign rdb_o[g]  = bus[g].rdata_b;
        assign ack_o[g]  = {bus[g].ack1, bus[g].ack0};
        assign we_o[g]   = bus[g].ram_we_;
        assign le_o[g]   = bus[g].ram_le_;
        assign oea_o[g]  = bus[g].ram_oea_;
        assign oeb_o[g]  = bus[g].ram_oeb_;
        assign alo_o[g]  = bus[g].ram_alo_;
        assign busy_o[g] = bus[g].busy;

        // level-sensitive RAM: every clock with we low stores d at b
        always @(posedge clk) begin
            if (pre_we)                mem[pre_addr]     <= pre_data;
            else if (!bus[g].ram_we_)  mem[bus[g].ram_b] <= bus[g].ram_d;
        end
    end

    function automatic int wpv(input int i);
        return (i == 0) ? 1 : 3;
    endfunction

    task automatic chk4(input string tag, input int i, input logic [3:0] obs, input logic [3:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s inst=%0d clk=%0d observed=%h expected=%h", tag, i, kcur, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input int i, input logic obs, input logic exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s inst=%0d clk=%0d observed=%b expected=%b", tag, i, kcur, obs, exp);
        end
    endtask

    task automatic idle_chk(input int i);
        chk1("busy_idle", i, busy_o[i], 1'b0);
        chk1("we_idle",   i, we_o[i],   1'b1);
        chk1("le_idle",   i, le_o[i],   1'b1);
        chk1("oea_idle",  i, oea_o[i],  1'b1);
        chk1("oeb_idle",  i, oeb_o[i],  1'b1);
        chk1("alo_idle",  i, alo_o[i],  1'b1);
        chk4("ack_idle",  i, 4'(ack_o[i]), 4'h0);
    endtask

    task automatic zero_chk(input int i);
        chk4("ram_a_rst", i, ra_o[i],  4'h0);
        chk4("ram_b_rst", i, rb_o[i],  4'h0);
        chk4("ram_d_rst", i, rd_o[i],  4'h0);
        chk4("rda_rst",   i, rda_o[i], 4'h0);
        chk4("rdb_rst",   i, rdb_o[i], 4'h0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req_v[0] = 2'b00;
        req_v[1] = 2'b00;
        repeat (2) @(posedge clk);
        @(negedge clk);
        kcur = 0;
        for (int i = 0; i < 2; i++) begin
            idle_chk(i);
            zero_chk(i);
            last_ra[i] = 4'h0;
            last_rb[i] = 4'h0;
            ptr_m[i]   = 1'b0;
        end
        rst = 1'b0;
    endtask

    task automatic preload(input logic [3:0] addr, input logic [3:0] data);
        pre_we   = 1'b1;
        pre_addr = addr;
        pre_data = data;
        @(posedge clk);
        @(negedge clk);
        pre_we = 1'b0;
        mem_m[addr] = data;
    endtask

    // One single-requester operation on both instances; rst_at>0 asserts reset during that clock.
    task automatic run_op(input bit who, input bit wr, input logic [3:0] a, input logic [3:0] b,
                          input logic [3:0] d, input int rst_at);
        int ackc [2];
        int kend;
        bit ab;
        ackc[0] = wr ? 3 + wpv(0) : 4;
        ackc[1] = wr ? 3 + wpv(1) : 4;
        kend = (rst_at != 0) ? rst_at + 3 : ackc[1] + 1;
        wr_v[who] = wr;  aa_v[who] = a;  ba_v[who] = b;  wd_v[who] = d;
        wr_v[!who] = 1'($urandom);
        aa_v[!who] = 4'($urandom);
        ba_v[!who] = 4'($urandom);
        wd_v[!who] = 4'($urandom);
        req_v[0] = who ? 2'b10 : 2'b01;
        req_v[1] = who ? 2'b10 : 2'b01;
        for (int k = 1; k <= kend; k++) begin
            @(posedge clk);
            @(negedge clk);
            kcur = k;
            ab = (rst_at != 0) && (k > rst_at);
            for (int i = 0; i < 2; i++) begin
                if (ab) begin
                    idle_chk(i);
                    zero_chk(i);
                end else if (k > ackc[i]) begin
                    idle_chk(i);
                end else begin
                    chk1("busy", i, busy_o[i], 1'b1);
                    chk1("we",   i, we_o[i],  (wr && k >= 2 && k <= 1 + wpv(i)) ? 1'b0 : 1'b1);
                    chk1("le",   i, le_o[i],  (!wr && k == 2) ? 1'b0 : 1'b1);
                    chk1("oea",  i, oea_o[i], (!wr && k == 3) ? 1'b0 : 1'b1);
                    chk1("oeb",  i, oeb_o[i], (!wr && k == 3) ? 1'b0 : 1'b1);
                    chk1("alo",  i, alo_o[i], 1'b1);
                    chk4("ack",  i, 4'(ack_o[i]), (k == ackc[i]) ? (who ? 4'h2 : 4'h1) : 4'h0);
                    chk4("ram_a", i, ra_o[i], a);
                    chk4("ram_b", i, rb_o[i], b);
                    chk4("ram_d", i, rd_o[i], d);
                    if (k == ackc[i] && !wr) begin
                        last_ra[i] = mem_m[a];
                        last_rb[i] = mem_m[b];
                    end
                    chk4("rdata_a", i, rda_o[i], last_ra[i]);
                    chk4("rdata_b", i, rdb_o[i], last_rb[i]);
                    if (k == ackc[i]) begin
                        req_v[i] = 2'b00;
                        ptr_m[i] = !who;
                    end
                end
            end
            wr_v[0] = 1'($urandom);  wr_v[1] = 1'($urandom);
            aa_v[0] = 4'($urandom);  aa_v[1] = 4'($urandom);
            ba_v[0] = 4'($urandom);  ba_v[1] = 4'($urandom);
            wd_v[0] = 4'($urandom);  wd_v[1] = 4'($urandom);
            if (rst_at != 0 && k == rst_at) begin
                rst = 1'b1;
                req_v[0] = 2'b00;
                req_v[1] = 2'b00;
            end
            if (rst_at != 0 && k == rst_at + 1) rst = 1'b0;
        end
        if (rst_at != 0) begin
            for (int i = 0; i < 2; i++) begin
                last_ra[i] = 4'h0;
                last_rb[i] = 4'h0;
                ptr_m[i]   = 1'b0;
            end
        end
        if (wr && (rst_at == 0 || rst_at >= 2)) mem_m[b] = d;
    endtask

    // Both requesters read continuously until each instance has completed 4 operations.
    task automatic contention();
        int cnt [2];
        int k;
        bit g;
        wr_v[0] = 1'b0;  aa_v[0] = 4'h1;  ba_v[0] = 4'h2;  wd_v[0] = 4'($urandom);
        wr_v[1] = 1'b0;  aa_v[1] = 4'h3;  ba_v[1] = 4'h4;  wd_v[1] = 4'($urandom);
        cnt[0] = 0;
        cnt[1] = 0;
        k = 0;
        req_v[0] = 2'b11;
        req_v[1] = 2'b11;
        while ((cnt[0] < 4 || cnt[1] < 4) && k < 60) begin
            @(posedge clk);
            @(negedge clk);
            k++;
            kcur = k;
            for (int i = 0; i < 2; i++) begin
                if (cnt[i] < 4 && ack_o[i] != 2'b00) begin
                    g = ack_o[i][1];
`ifdef AM29705_CTL_RR_EN
                    chk1("grant_rr", i, g, ptr_m[i]);
                    ptr_m[i] = !g;
`else
                    chk1("grant_fixed", i, g, 1'b0);
`endif
                    chk4("ack_onehot", i, 4'(ack_o[i]), g ? 4'h2 : 4'h1);
                    last_ra[i] = mem_m[g ? 3 : 1];
                    last_rb[i] = mem_m[g ? 4 : 2];
                    chk4("cont_rdata_a", i, rda_o[i], last_ra[i]);
                    chk4("cont_rdata_b", i, rdb_o[i], last_rb[i]);
                    cnt[i]++;
                    if (cnt[i] == 4) req_v[i] = 2'b00;
                end
            end
        end
        for (int i = 0; i < 2; i++) chk4("cont_ops", i, 4'(cnt[i]), 4'h4);
        req_v[0] = 2'b00;
        req_v[1] = 2'b00;
        @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < 2; i++) idle_chk(i);
    endtask

    initial begin
        req_v[0] = 2'b00;  req_v[1] = 2'b00;
        wr_v[0] = 1'b0;    wr_v[1] = 1'b0;
        aa_v[0] = 4'h0;    aa_v[1] = 4'h0;
        ba_v[0] = 4'h0;    ba_v[1] = 4'h0;
        wd_v[0] = 4'h0;    wd_v[1] = 4'h0;
        for (int n = 0; n < 16; n++) preload(4'(n), 4'($urandom));
        do_reset();

        // write 0xA to address 5 straight out of reset
        run_op(1'b0, 1'b1, 4'h0, 4'h5, 4'hA, 0);

        // read-back of preloaded [3]=0x6 and the written [5]=0xA by requester 1
        preload(4'h3, 4'h6);
        run_op(1'b1, 1'b0, 4'h3, 4'h5, 4'h0, 0);

        // explicit write, then reset during the second WRITE clock and read back the partial write
        run_op(1'b0, 1'b1, 4'h7, 4'h9, 4'h3, 0);
        run_op(1'b0, 1'b1, 4'h2, 4'h9, 4'hC, 3);
        run_op(1'b1, 1'b0, 4'h9, 4'h9, 4'h0, 0);

        for (int n = 0; n < 30; n++)
            run_op(1'($urandom), 1'($urandom), 4'($urandom), 4'($urandom), 4'($urandom), 0);

        do_reset();
        contention();

        for (int n = 0; n < 15; n++)
            run_op(1'($urandom), 1'($urandom), 4'($urandom), 4'($urandom), 4'($urandom), 0);
        contention();

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
